// File: rtl/dual_frame_rd_mux.sv
// Read-side frame mux: reloads the DDR read path on each frame start, then
// answers HDMI pixel requests from one or both camera read FIFOs.
module dual_frame_rd_mux #(
    parameter logic [15:0] BLANK_RGB   = 16'h0000,
    parameter int unsigned LOAD_CYCLES = 4,
    parameter int unsigned XW          = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic          video_vs,
    input  logic          data_req,
    input  logic [XW-1:0] pixel_xpos,
    input  logic [12:0]   h_disp,
    output logic          rd_load,
    output logic          rd_en_1,
    output logic          rd_en_2,
    input  logic [15:0]   rd_data_1,
    input  logic [15:0]   rd_data_2,
    input  logic          rd_empty_1,
    input  logic          rd_empty_2,
    output logic [15:0]   pic_data,
    output logic          pic_valid,
    output logic          frame_active,
    output logic [15:0]   underflow_cnt_1,
    output logic [15:0]   underflow_cnt_2,
    output logic [1:0]    state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam int unsigned CW   = 4;
    localparam int unsigned SW   = 12;
    localparam int unsigned CMPW = (XW > SW) ? XW : SW;

    logic          vs_q;
    logic          vs_rise;
    logic          frame_start;
    logic          pix_active;
    logic          lockstep;
    logic          sel_2;
    logic          need_1;
    logic          need_2;
    logic          pop_sel;
    logic          sel_q;
    logic          popped_q;
    logic [1:0]    mode_q;
    logic [SW-1:0] split_q;
    logic [CW-1:0] load_cnt;
    logic [CW-1:0] load_cnt_nxt;
    logic [1:0]    next_state;
    logic          rd_load_nxt;
    logic          unused_hdisp_lsb;

    assign unused_hdisp_lsb = h_disp[0];

    // Frame start qualification and pixel-path enable for this cycle
    assign vs_rise     = video_vs & ~vs_q;
    assign frame_start = vs_rise & enable;
    assign pix_active  = (state == S_RUN) & enable & ~vs_rise;

    // Channel select and per-FIFO demand; single modes pop both FIFOs in lockstep
    assign lockstep = (mode_q != 2'd0);
    assign sel_2    = (mode_q == 2'd2) |
                      ((mode_q == 2'd0) & ~(CMPW'(pixel_xpos) < CMPW'(split_q)));
    assign need_1   = pix_active & data_req & (lockstep | ~sel_2);
    assign need_2   = pix_active & data_req & (lockstep | sel_2);
    assign rd_en_1  = need_1 & ~rd_empty_1;
    assign rd_en_2  = need_2 & ~rd_empty_2;
    assign pop_sel  = sel_2 ? rd_en_2 : rd_en_1;

    // FIFO data arrives the cycle after the pop, so the mux follows the registered select
    assign pic_data = popped_q ? (sel_q ? rd_data_2 : rd_data_1) : BLANK_RGB;

    // Next-state logic: enable loss wins, then frame start restarts LOAD
    always_comb begin
        next_state   = state;
        load_cnt_nxt = load_cnt;
        rd_load_nxt  = 1'b0;
        if (!enable) begin
            next_state = S_IDLE;
        end else if (frame_start) begin
            next_state   = S_LOAD;
            load_cnt_nxt = CW'(LOAD_CYCLES - 1);
            rd_load_nxt  = 1'b1;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_cnt == '0) begin
                        next_state = S_FILL;
                    end else begin
                        load_cnt_nxt = load_cnt - CW'(1);
                        rd_load_nxt  = 1'b1;
                    end
                end
                S_FILL: begin
                    if (!rd_empty_1 && !rd_empty_2) begin
                        next_state = S_RUN;
                    end
                end
                default: begin
                    next_state = state;
                end
            endcase
        end
    end

    // FSM state, load pulse and frame-start latches
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q         <= 1'b0;
            state        <= S_IDLE;
            load_cnt     <= '0;
            rd_load      <= 1'b0;
            frame_active <= 1'b0;
            mode_q       <= 2'd0;
            split_q      <= '0;
        end else begin
            vs_q         <= video_vs;
            state        <= next_state;
            load_cnt     <= load_cnt_nxt;
            rd_load      <= rd_load_nxt;
            frame_active <= (next_state == S_RUN);
            if (frame_start) begin
                mode_q  <= (mode == 2'd3) ? 2'd0 : mode;
                split_q <= h_disp[12:1];
            end
        end
    end

    // Request pipeline: one-cycle request-to-pixel latency
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= 1'b0;
            popped_q  <= 1'b0;
            pic_valid <= 1'b0;
        end else begin
            sel_q     <= sel_2;
            popped_q  <= pop_sel;
            pic_valid <= data_req;
        end
    end

    // Saturating underflow counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt_1 <= '0;
            underflow_cnt_2 <= '0;
        end else begin
            if (need_1 && rd_empty_1 && (underflow_cnt_1 != 16'hFFFF)) begin
                underflow_cnt_1 <= underflow_cnt_1 + 16'd1;
            end
            if (need_2 && rd_empty_2 && (underflow_cnt_2 != 16'hFFFF)) begin
                underflow_cnt_2 <= underflow_cnt_2 + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dual_frame_rd_mux.sv
// Bench for dual_frame_rd_mux: queue-based FIFO environment, behavioural
// reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_dual_frame_rd_mux;

    localparam logic [15:0] BLANK = 16'h0000;
    localparam int          LOADC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        video_vs = 1'b0;
    logic        data_req = 1'b0;
    logic [10:0] pixel_xpos = '0;
    logic [12:0] h_disp = 13'd8;
    logic        rd_load;
    logic        rd_en_1, rd_en_2;
    logic [15:0] rd_data_1 = '0, rd_data_2 = '0;
    logic        rd_empty_1 = 1'b1, rd_empty_2 = 1'b1;
    logic [15:0] pic_data;
    logic        pic_valid;
    logic        frame_active;
    logic [15:0] underflow_cnt_1, underflow_cnt_2;
    logic [1:0]  state;

    dual_frame_rd_mux #(.BLANK_RGB(BLANK), .LOAD_CYCLES(LOADC), .XW(11)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .video_vs(video_vs),
        .data_req(data_req), .pixel_xpos(pixel_xpos), .h_disp(h_disp),
        .rd_load(rd_load), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .rd_empty_1(rd_empty_1), .rd_empty_2(rd_empty_2),
        .pic_data(pic_data), .pic_valid(pic_valid), .frame_active(frame_active),
        .underflow_cnt_1(underflow_cnt_1), .underflow_cnt_2(underflow_cnt_2),
        .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO contents owned by the bench
    logic [15:0] q1[$];
    logic [15:0] q2[$];

    // Reference model: phase 0 idle, 1 load, 2 fill, 3 run
    bit          m_live = 1'b0;
    int          m_state = 0;
    int          m_left = 0;
    int          m_mode = 0;
    int          m_split = 0;
    logic        m_vsq = 1'b0;
    logic [15:0] m_cnt1 = '0, m_cnt2 = '0;
    logic [15:0] m_pd = BLANK;
    logic        m_pv = 1'b0;

    // Which FIFOs the current request needs, and whether camera 2 is shown
    function automatic void m_need(output bit n1, output bit n2, output bit s2);
        bit act;
        act = (m_state == 3) && enable && !(video_vs && !m_vsq);
        s2  = (m_mode == 2) || (m_mode == 0 && int'(pixel_xpos) >= m_split);
        n1  = act && data_req && (m_mode != 0 || !s2);
        n2  = act && data_req && (m_mode != 0 || s2);
    endfunction

    // Model update and FIFO environment at each rising edge
    always @(posedge clk) begin
        bit n1, n2, s2, p1, p2, fs;
        logic [15:0] f1, f2;
        m_need(n1, n2, s2);
        p1 = n1 && !rd_empty_1;
        p2 = n2 && !rd_empty_2;
        f1 = (q1.size() > 0) ? q1[0] : 16'h0;
        f2 = (q2.size() > 0) ? q2[0] : 16'h0;
        if (rst) begin
            m_live = 1'b1; m_state = 0; m_left = 0; m_mode = 0; m_split = 0;
            m_vsq = 1'b0; m_cnt1 = '0; m_cnt2 = '0; m_pd = BLANK; m_pv = 1'b0;
        end else begin
            m_pv = data_req;
            m_pd = BLANK;
            if (!s2 && p1) m_pd = f1;
            if (s2 && p2)  m_pd = f2;
            if (n1 && rd_empty_1 && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
            if (n2 && rd_empty_2 && m_cnt2 != 16'hFFFF) m_cnt2 = m_cnt2 + 16'd1;
            fs = video_vs && !m_vsq && enable;
            if (!enable) begin
                m_state = 0;
            end else if (fs) begin
                m_state = 1;
                m_left  = LOADC;
                m_mode  = (mode == 2'd3) ? 0 : int'(mode);
                m_split = int'(h_disp) / 2;
            end else if (m_state == 1) begin
                m_left = m_left - 1;
                if (m_left == 0) m_state = 2;
            end else if (m_state == 2 && !rd_empty_1 && !rd_empty_2) begin
                m_state = 3;
            end
            m_vsq = video_vs;
        end
        if (rd_en_1 === 1'b1 && q1.size() > 0) rd_data_1 <= q1.pop_front();
        if (rd_en_2 === 1'b1 && q2.size() > 0) rd_data_2 <= q2.pop_front();
        rd_empty_1 <= (q1.size() == 0);
        rd_empty_2 <= (q2.size() == 0);
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        bit n1, n2, s2;
        if (m_live) begin
            m_need(n1, n2, s2);
            chk("state", 32'(state), 32'(m_state));
            chk("rd_load", 32'(rd_load), 32'(m_state == 1));
            chk("frame_active", 32'(frame_active), 32'(m_state == 3));
            chk("rd_en_1", 32'(rd_en_1), 32'(n1 && !rd_empty_1));
            chk("rd_en_2", 32'(rd_en_2), 32'(n2 && !rd_empty_2));
            chk("pic_valid", 32'(pic_valid), 32'(m_pv));
            chk("pic_data", 32'(pic_data), 32'(m_pd));
            chk("underflow_cnt_1", 32'(underflow_cnt_1), 32'(m_cnt1));
            chk("underflow_cnt_2", 32'(underflow_cnt_2), 32'(m_cnt2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vsync rise with the given mode, then wait for RUN
    task automatic frame(input logic [1:0] m, input string nm);
        int k;
        data_req = 1'b0;
        mode = m;
        video_vs = 1'b1;
        tick();
        video_vs = 1'b0;
        k = 0;
        while (m_state != 3 && k < 100) begin
            tick();
            k++;
        end
        chk(nm, 32'(state), 32'd3);
    endtask

    logic [15:0] rec_pd[8];
    int          n_en1, n_en2, n_load;

    // One request per cycle for xpos base..base+n-1, recording pixels and pops
    task automatic run_reqs(input int base, input int n);
        n_en1 = 0;
        n_en2 = 0;
        for (int i = 0; i < n; i++) begin
            data_req = 1'b1;
            pixel_xpos = 11'(base + i);
            #1;
            if (rd_en_1) n_en1++;
            if (rd_en_2) n_en2++;
            @(posedge clk);
            #1;
            if (i < 8) rec_pd[i] = pic_data;
        end
        data_req = 1'b0;
        tick();
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pic_data", 32'(pic_data), 32'(BLANK));
        chk("rst_pic_valid", 32'(pic_valid), 32'd0);
        chk("rst_rd_load", 32'(rd_load), 32'd0);
        chk("rst_cnt1", 32'(underflow_cnt_1), 32'd0);
        rst = 1'b0;
        enable = 1'b1;
        h_disp = 13'd8;
        tick();

        // Load pulse width after a vsync rise
        mode = 2'd0;
        video_vs = 1'b1;
        tick();
        video_vs = 1'b0;
        chk("load_first_state", 32'(state), 32'd1);
        chk("load_first_pulse", 32'(rd_load), 32'd1);
        n_load = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_load) n_load++;
        end
        chk("load_width", 32'(n_load), 32'd4);
        chk("load_then_fill", 32'(state), 32'd2);

        // Side-by-side with constant-colour FIFOs
        for (int i = 0; i < 4; i++) begin
            q1.push_back(16'h1111);
            q2.push_back(16'h2222);
        end
        begin
            int k = 0;
            while (m_state != 3 && k < 20) begin tick(); k++; end
        end
        chk("sbs_run", 32'(state), 32'd3);
        run_reqs(0, 8);
        chk("sbs_en1", 32'(n_en1), 32'd4);
        chk("sbs_en2", 32'(n_en2), 32'd4);
        for (int i = 0; i < 8; i++)
            chk($sformatf("sbs_pix%0d", i), 32'(rec_pd[i]), (i < 4) ? 32'h1111 : 32'h2222);

        // Camera 2 only, lockstep popping
        for (int i = 0; i < 8; i++) begin
            q1.push_back(16'h1000 + 16'(i));
            q2.push_back(16'h2000 + 16'(i));
        end
        tick();
        frame(2'd2, "cam2_run");
        run_reqs(0, 8);
        chk("cam2_en1", 32'(n_en1), 32'd8);
        chk("cam2_en2", 32'(n_en2), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("cam2_pix%0d", i), 32'(rec_pd[i]), 32'h2000 + 32'(i));

        // Underflow on camera 1 in side-by-side
        q1.push_back(16'hAAAA);
        q2.push_back(16'hBBBB);
        tick();
        frame(2'd0, "uf_run");
        run_reqs(0, 1);
        chk("uf_first_pix", 32'(rec_pd[0]), 32'hAAAA);
        run_reqs(1, 3);
        chk("uf_en1", 32'(n_en1), 32'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("uf_blank%0d", i), 32'(rec_pd[i]), 32'h0000);
        chk("uf_cnt1", 32'(underflow_cnt_1), 32'd3);

        // Enable dropped mid-run
        enable = 1'b0;
        tick();
        chk("dis_state", 32'(state), 32'd0);
        run_reqs(0, 2);
        chk("dis_en1", 32'(n_en1), 32'd0);
        chk("dis_pix", 32'(rec_pd[1]), 32'(BLANK));
        enable = 1'b1;
        tick();

        // Second vsync rise during LOAD restarts the pulse
        video_vs = 1'b1; tick();
        video_vs = 1'b0; tick();
        video_vs = 1'b1; tick();
        video_vs = 1'b0;
        chk("reload_pulse", 32'(rd_load), 32'd1);
        n_load = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_load) n_load++;
        end
        chk("reload_width", 32'(n_load), 32'd4);

        // Randomised traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int hd;
            enable = ($urandom_range(0, 60) != 0);
            if ($urandom_range(0, 150) == 0) begin
                video_vs = 1'b1;
                mode = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: h_disp = 13'd8;
                    1: h_disp = 13'd16;
                    2: h_disp = 13'd21;
                    default: h_disp = 13'd1280;
                endcase
            end else begin
                video_vs = ($urandom_range(0, 3) == 0) ? 1'b0 : video_vs;
            end
            hd = (int'(h_disp) > 0) ? int'(h_disp) : 1;
            data_req = ($urandom_range(0, 9) < 6);
            pixel_xpos = 11'($urandom_range(0, hd - 1));
            if (q1.size() < 32 && $urandom_range(0, 2) == 0) q1.push_back(16'($urandom));
            if (q2.size() < 32 && $urandom_range(0, 2) == 0) q2.push_back(16'($urandom));
            tick();
        end
        data_req = 1'b0;
        video_vs = 1'b0;
        enable = 1'b1;
        tick();

        // Saturation of both counters in camera 1 only mode
        q1.push_back(16'h5555);
        q2.push_back(16'h6666);
        tick();
        frame(2'd1, "sat_run");
        data_req = 1'b1;
        pixel_xpos = 11'd0;
        begin
            int k = 0;
            while ((m_cnt1 != 16'hFFFF || m_cnt2 != 16'hFFFF) && k < 70000) begin
                tick();
                k++;
            end
        end
        repeat (3) tick();
        data_req = 1'b0;
        tick();
        chk("sat_cnt1", 32'(underflow_cnt_1), 32'hFFFF);
        chk("sat_cnt2", 32'(underflow_cnt_2), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
